// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding, default bus widths, response bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // One registered response beat. rdata/err/timeout are only meaningful while valid=1.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
        logic                  valid;
    } apb_rsp_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: cleared on clr, counts inc cycles, flags expire on the TIMEOUT-th counted cycle.
// Latency: expire is combinational from the counter register; the count updates one edge after inc.
// Backpressure: none; the counter saturates at all-ones. TIMEOUT=0 keeps expire permanently low.
// Ports: clk/rst (sync, active-high), clr (zero the count), inc (one more stalled cycle), expire (limit reached).
module apb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    // A zero TIMEOUT still needs a legal (1-bit) counter even though expire never fires.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt holds the number of stalled ACCESS cycles already seen, so the current
    // cycle is the TIMEOUT-th one when cnt reaches TIMEOUT-1.
    assign expire = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: runs one valid/ready command at a time as an APB SETUP->ACCESS transfer, returns a 1-cycle response pulse.
// Latency: 3 cycles accept-to-response with a zero-wait slave, +1 per wait state; watchdog aborts after TIMEOUT stalled ACCESS cycles.
// Backpressure: cmd_ready is low while a transfer is in flight; the response has no backpressure.
// Ports: pclk/preset (sync, active-high); cmd_* command port; rsp_* response pulse; busy; psel/penable/pwrite/paddr/pwdata
//        drive the APB slave, prdata/pready/pslverr come back from it.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // The response bundle carries rdata at the package width, so wider data buses cannot be represented.
    if (DATA_W > APB_DATA_W) begin : g_width_check
        $error("apb_master_bridge: DATA_W exceeds APB_DATA_W");
    end

    apb_state_e state;
    apb_rsp_t   rsp_q;

    logic wd_clr;
    logic wd_inc;
    logic wd_expire;

    assign wd_clr = (state == SETUP);
    assign wd_inc = (state == ACCESS) && !pready;

    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (pclk),
        .rst    (preset),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expire (wd_expire)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            // Any in-flight transfer is dropped silently: no response is generated.
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            rsp_q   <= '0;
        end else begin
            // Response is a single-cycle pulse; the payload fields keep their last value.
            rsp_q.valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_q.valid   <= 1'b1;
                        rsp_q.rdata   <= pwrite ? '0 : APB_DATA_W'(prdata);
                        rsp_q.err     <= pslverr;
                        rsp_q.timeout <= 1'b0;
                        state         <= IDLE;
                    end else if (wd_expire) begin
                        psel          <= 1'b0;
                        penable       <= 1'b0;
                        rsp_q.valid   <= 1'b1;
                        rsp_q.rdata   <= '0;
                        rsp_q.err     <= 1'b1;
                        rsp_q.timeout <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Both are straight decodes of the state register, so they are glitch-free and
    // cmd_ready is already high in the first cycle after reset.
    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);

    assign rsp_valid   = rsp_q.valid;
    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule
